lut_multi_read: RTL and testbench

Multi-lane lookup-table unit for the Versat datapath: loads a table from external memory over the databus into a replicated dual-port RAM, then serves NUM_LANES independent indexed reads per cycle with fixed 2-cycle latency. Generalises the single-lane table reader:

- Read lanes are parametrised.
- Entry width is derived from parameters, not hard-coded.
- The loader is a contiguous-burst FSM with restart-on-run.
- Ping-pong banking lets one table be read while the next is loaded.

---
 rtl/lut_multi_read_pkg.sv | 36 +++
 rtl/lut_read_lane.sv | 80 ++++++++
 rtl/lut_multi_read.sv | 156 +++++++++++++++
 tb/tb_lut_multi_read.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_multi_read_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_multi_read_pkg
//  Description : Shared types and helpers for the multi-lane lookup-table unit
//  Revision    : 1.0 - initial release
// ============================================================================
package lut_multi_read_pkg;

    // Loader state: waiting for a run, or streaming a table burst into RAM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } load_state_t;

    // Narrowest register width allowed for the lane-select pipeline
    localparam int C_MIN_SEL_BITS = 1;

    // Number of index bits selecting an entry inside one RAM word (0 if DIFF=1)
    function automatic int calc_sel_w(input int diff);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < diff) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Bit offset of lane `lane` inside a packed per-lane bus of `width`-bit fields
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_read_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lut_read_lane
//  Description : One read lane: index -> RAM word address, entry-select
//                pipeline and DIFF:1 slice mux. Fixed 2-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_read_lane #(
    parameter int DATA_W     = 32,
    parameter int AXI_DATA_W = 32,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_bank,
    input  logic                  i_ping_pong,
    input  logic [DATA_W-1:0]     i_idx,
    input  logic [AXI_DATA_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0]     o_rd_addr,
    output logic [DATA_W-1:0]     o_data
);
    import lut_multi_read_pkg::*;

    localparam int DIFF     = AXI_DATA_W / DATA_W;
    localparam int SEL_W    = calc_sel_w(DIFF);
    localparam int SEL_BITS = (SEL_W > 0) ? SEL_W : C_MIN_SEL_BITS;

    logic [DATA_W+ADDR_W-1:0] w_idx_ext;
    logic [ADDR_W-1:0]        w_word;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [SEL_BITS-1:0]      w_sel;
    logic [ADDR_W-1:0]        r_rd_addr;
    logic [SEL_BITS-1:0]      r_sel0;
    logic [SEL_BITS-1:0]      r_sel1;
    logic                     w_unused_idx;

    // Zero-extend before shifting so narrow indices still fill the address;
    // index bits above the addressable range simply drop off.
    assign w_idx_ext    = {{ADDR_W{1'b0}}, i_idx} >> SEL_W;
    assign w_word       = w_idx_ext[ADDR_W-1:0];
    assign w_unused_idx = ^w_idx_ext;

    // Reads come from the bank the loader is not currently filling
    assign w_rd_addr = i_ping_pong ? {~i_bank, w_word[ADDR_W-2:0]} : w_word;

    generate
        if (SEL_W > 0) begin : g_sel
            assign w_sel = i_idx[SEL_BITS-1:0];
        end else begin : g_no_sel
            assign w_sel = '0;
        end
    endgenerate

    // Register the RAM address and carry the entry select alongside the RAM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_sel0    <= '0;
            r_sel1    <= '0;
        end else begin
            r_rd_addr <= w_rd_addr;
            r_sel0    <= w_sel;
            r_sel1    <= r_sel0;
        end
    end

    // Pick the DATA_W entry out of the returned RAM word
    always_comb begin
        o_data = i_rd_data[DATA_W-1:0];
        for (int s = 0; s < DIFF; s++) begin
            if (int'(r_sel1) == s) begin
                o_data = i_rd_data[s*DATA_W +: DATA_W];
            end
        end
    end

    assign o_rd_addr = r_rd_addr;

endmodule
`default_nettype wire

// File: rtl/lut_multi_read.sv
`default_nettype none
// ============================================================================
//  Module      : lut_multi_read
//  Description : Multi-lane lookup table. Loads a table over the databus into
//                a replicated RAM (optionally ping-pong banked) and serves
//                NUM_LANES indexed reads per cycle with 2-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_multi_read #(
    parameter int DATA_W     = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 8,
    parameter int NUM_LANES  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic                            running,
    input  logic                            disabled,
    input  logic [AXI_ADDR_W-1:0]           ext_addr,
    input  logic [LEN_W-1:0]                length,
    input  logic                            pingPong,
    output logic                            databus_valid_0,
    input  logic                            databus_ready_0,
    output logic [AXI_ADDR_W-1:0]           databus_addr_0,
    input  logic [AXI_DATA_W-1:0]           databus_rdata_0,
    output logic [AXI_DATA_W-1:0]           databus_wdata_0,
    output logic [AXI_DATA_W/8-1:0]         databus_wstrb_0,
    output logic [LEN_W-1:0]                databus_len_0,
    input  logic                            databus_last_0,
    output logic                            done,
    input  logic [NUM_LANES*DATA_W-1:0]     in_i,
    output logic [NUM_LANES*DATA_W-1:0]     out_o,
    output logic [NUM_LANES*ADDR_W-1:0]     ext_rd_addr_o,
    output logic [NUM_LANES-1:0]            ext_rd_en_o,
    input  logic [NUM_LANES*AXI_DATA_W-1:0] ext_rd_data_i,
    output logic                            ext_wr_en_o,
    output logic [ADDR_W-1:0]               ext_wr_addr_o,
    output logic [AXI_DATA_W-1:0]           ext_wr_data_o
);
    import lut_multi_read_pkg::*;

    load_state_t           r_state;
    load_state_t           w_state_next;
    logic                  r_bank;
    logic                  r_done;
    logic [ADDR_W-1:0]     r_wr_cnt;
    logic [ADDR_W-1:0]     w_wr_cnt_inc;
    logic [ADDR_W-1:0]     w_wr_cnt_next;
    logic [AXI_ADDR_W-1:0] r_ext_addr;
    logic                  w_start;
    logic                  w_beat;
    logic                  w_unused;

    assign w_unused = running;
    assign w_start  = run & ~disabled;

    // In ping-pong mode the counter lives in half the space, the MSB being the bank
    assign w_wr_cnt_inc  = r_wr_cnt + ADDR_W'(1);
    assign w_wr_cnt_next = pingPong ? {1'b0, w_wr_cnt_inc[ADDR_W-2:0]} : w_wr_cnt_inc;

    // Loader state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Loader next state, bus request and write strobe; a restart beats a last beat
    always_comb begin
        w_state_next    = r_state;
        databus_valid_0 = 1'b0;
        ext_wr_en_o     = 1'b0;
        w_beat          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                databus_valid_0 = 1'b1;
                w_beat          = databus_ready_0;
                ext_wr_en_o     = databus_ready_0;
                if (w_start) begin
                    w_state_next = ST_LOAD;
                end else if (databus_ready_0 && databus_last_0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bank select, write counter, latched source address and completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank     <= 1'b0;
            r_wr_cnt   <= '0;
            r_done     <= 1'b1;
            r_ext_addr <= '0;
        end else begin
            if (run) begin
                r_bank <= pingPong ? ~r_bank : 1'b0;
            end
            if (w_start) begin
                r_ext_addr <= ext_addr;
                r_wr_cnt   <= '0;
                r_done     <= 1'b0;
            end else if (w_beat) begin
                r_wr_cnt <= w_wr_cnt_next;
                if (databus_last_0) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign ext_wr_addr_o   = pingPong ? {r_bank, r_wr_cnt[ADDR_W-2:0]} : r_wr_cnt;
    assign ext_wr_data_o   = databus_rdata_0;
    assign databus_addr_0  = r_ext_addr;
    assign databus_len_0   = length;
    assign databus_wdata_0 = '0;
    assign databus_wstrb_0 = '0;
    assign done            = r_done;
    assign ext_rd_en_o     = '1;

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            localparam int C_IDX_LSB  = lane_lsb(k, DATA_W);
            localparam int C_ADDR_LSB = lane_lsb(k, ADDR_W);
            localparam int C_RAM_LSB  = lane_lsb(k, AXI_DATA_W);

            lut_read_lane #(
                .DATA_W     (DATA_W),
                .AXI_DATA_W (AXI_DATA_W),
                .ADDR_W     (ADDR_W)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .i_bank      (r_bank),
                .i_ping_pong (pingPong),
                .i_idx       (in_i[C_IDX_LSB +: DATA_W]),
                .i_rd_data   (ext_rd_data_i[C_RAM_LSB +: AXI_DATA_W]),
                .o_rd_addr   (ext_rd_addr_o[C_ADDR_LSB +: ADDR_W]),
                .o_data      (out_o[C_IDX_LSB +: DATA_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lut_multi_read.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_multi_read
//  Description : Directed bench for lut_multi_read (64-bit words, 32-bit
//                entries, two lanes, 8-bit RAM address) with a behavioural
//                table model and literal spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_multi_read;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int RA = 8;
    localparam int NL = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                run = 1'b0;
    logic                running = 1'b1;
    logic                disabled = 1'b0;
    logic [31:0]         ext_addr = '0;
    logic [7:0]          length = 8'd4;
    logic                pingPong = 1'b0;
    logic                databus_valid_0;
    logic                databus_ready_0 = 1'b0;
    logic [31:0]         databus_addr_0;
    logic [AW-1:0]       databus_rdata_0 = '0;
    logic [AW-1:0]       databus_wdata_0;
    logic [AW/8-1:0]     databus_wstrb_0;
    logic [7:0]          databus_len_0;
    logic                databus_last_0 = 1'b0;
    logic                done;
    logic [NL*DW-1:0]    in_i = '0;
    logic [NL*DW-1:0]    out_o;
    logic [NL*RA-1:0]    ext_rd_addr_o;
    logic [NL-1:0]       ext_rd_en_o;
    logic [NL*AW-1:0]    ext_rd_data_i;
    logic                ext_wr_en_o;
    logic [RA-1:0]       ext_wr_addr_o;
    logic [AW-1:0]       ext_wr_data_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lut_multi_read #(
        .DATA_W(DW), .AXI_DATA_W(AW), .AXI_ADDR_W(32),
        .ADDR_W(RA), .LEN_W(8), .NUM_LANES(NL)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .running(running), .disabled(disabled),
        .ext_addr(ext_addr), .length(length), .pingPong(pingPong),
        .databus_valid_0(databus_valid_0), .databus_ready_0(databus_ready_0),
        .databus_addr_0(databus_addr_0), .databus_rdata_0(databus_rdata_0),
        .databus_wdata_0(databus_wdata_0), .databus_wstrb_0(databus_wstrb_0),
        .databus_len_0(databus_len_0), .databus_last_0(databus_last_0),
        .done(done), .in_i(in_i), .out_o(out_o),
        .ext_rd_addr_o(ext_rd_addr_o), .ext_rd_en_o(ext_rd_en_o),
        .ext_rd_data_i(ext_rd_data_i), .ext_wr_en_o(ext_wr_en_o),
        .ext_wr_addr_o(ext_wr_addr_o), .ext_wr_data_o(ext_wr_data_o)
    );

    // Replicated read-first RAM driven by the DUT's RAM ports
    logic [AW-1:0] ram [256];
    bit            ram_init = 1'b0;
    always @(posedge clk) begin
        if (rst && !ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram_init <= 1'b1;
        end else begin
            if (ext_wr_en_o) ram[ext_wr_addr_o] <= ext_wr_data_o;
        end
        for (int l = 0; l < NL; l++)
            ext_rd_data_i[l*AW +: AW] <= ram[ext_rd_addr_o[l*RA +: RA]];
    end

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_mem [256];
    bit            m_init = 1'b0;
    bit            m_loading, m_bank, m_done;
    int            m_cnt, m_pipe;
    logic [31:0]   m_baddr;
    int            m_a1 [NL];
    bit            m_s1 [NL];
    logic [31:0]   m_out [NL];

    function automatic logic [AW-1:0] beat(input int i, input int off);
        logic [31:0] lo, hi;
        lo = 32'(2 * i + off);
        hi = 32'(2 * i + 1 + off);
        return {hi, lo};
    endfunction

    function automatic int rd_word(input logic [31:0] idx, input bit bank, input bit pp);
        int w;
        w = int'((idx >> 1) % 256);
        if (pp) w = (w % 128) + (bank ? 0 : 128);
        return w;
    endfunction

    function automatic int wr_word();
        if (pingPong) return (m_bank ? 128 : 0) + (m_cnt % 128);
        return m_cnt % 256;
    endfunction

    task automatic model_step();
        bit bt;
        bt = 1'b0;
        if (rst) begin
            m_loading = 0; m_cnt = 0; m_bank = 0; m_done = 1; m_baddr = '0; m_pipe = 0;
            if (!m_init) begin
                for (int i = 0; i < 256; i++) m_mem[i] = '0;
                m_init = 1;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                m_out[l] = m_s1[l] ? m_mem[m_a1[l]][63:32] : m_mem[m_a1[l]][31:0];
                m_a1[l]  = rd_word(in_i[l*DW +: DW], m_bank, pingPong);
                m_s1[l]  = in_i[l*DW];
            end
            if (m_pipe < 2) m_pipe++;
            if (m_loading && databus_ready_0) begin
                m_mem[wr_word()] = databus_rdata_0;
                m_cnt = (m_cnt + 1) % (pingPong ? 128 : 256);
                bt = 1'b1;
            end
            if (run) m_bank = pingPong ? !m_bank : 1'b0;
            if (run && !disabled) begin
                m_loading = 1; m_cnt = 0; m_baddr = ext_addr; m_done = 0;
            end else if (bt && databus_last_0) begin
                m_loading = 0; m_done = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            check("done", 64'(done), 64'(m_done));
            check("valid", 64'(databus_valid_0), 64'(m_loading));
            check("wr_en", 64'(ext_wr_en_o), 64'(m_loading && databus_ready_0));
            if (m_loading && databus_ready_0) begin
                check("wr_addr", 64'(ext_wr_addr_o), 64'(wr_word()));
                check("wr_data", ext_wr_data_o, databus_rdata_0);
            end
            check("bus_addr", 64'(databus_addr_0), 64'(m_baddr));
            check("bus_len", 64'(databus_len_0), 64'(length));
            if (m_pipe >= 2) begin
                for (int l = 0; l < NL; l++)
                    check($sformatf("out_lane%0d", l), 64'(out_o[l*DW +: DW]), 64'(m_out[l]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic send_beats(input int n, input int off, input bit use_last);
        for (int i = 0; i < n; i++) begin
            databus_ready_0 = 1'b1;
            databus_rdata_0 = beat(i, off);
            databus_last_0  = use_last && (i == n - 1);
            tick();
        end
        databus_ready_0 = 1'b0;
        databus_last_0  = 1'b0;
    endtask

    task automatic set_idx(input logic [31:0] a, input logic [31:0] b);
        in_i[0 +: DW]  = a;
        in_i[DW +: DW] = b;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_done", 64'(done), 64'd1);
        check("rst_valid", 64'(databus_valid_0), 64'd0);
        check("rst_wr_en", 64'(ext_wr_en_o), 64'd0);
        check("rst_rd_addr", 64'(ext_rd_addr_o), 64'd0);
        repeat (4) tick();

        // Plain load of entries 0..7
        ext_addr = 32'h1000;
        do_run();
        check("done_fell", 64'(done), 64'd0);
        check("addr_latch", 64'(databus_addr_0), 64'h1000);
        send_beats(4, 0, 1'b1);
        check("done_rose", 64'(done), 64'd1);
        set_idx(32'd5, 32'd2);
        tick();
        check("lat_not_early", 64'(out_o[0 +: DW]), 64'd0);
        tick();
        check("lut_lane0_5", 64'(out_o[0 +: DW]), 64'd5);
        check("lut_lane1_2", 64'(out_o[DW +: DW]), 64'd2);

        // Back-to-back lookups on both lanes
        for (int i = 0; i < 16; i++) begin
            set_idx(32'(i % 8), 32'((i * 3) % 8));
            tick();
        end
        set_idx(32'h0000_0203, 32'd7);
        tick();
        tick();
        check("idx_high_bits", 64'(out_o[0 +: DW]), 64'd3);
        check("lut_lane1_7", 64'(out_o[DW +: DW]), 64'd7);

        // Ping-pong: table A into bank 1, reads still see the old table
        pingPong = 1'b1;
        ext_addr = 32'h2000;
        set_idx(32'd3, 32'd4);
        do_run();
        send_beats(4, 200, 1'b1);
        tick();
        check("pp_read_old", 64'(out_o[0 +: DW]), 64'd3);
        // Table B into bank 0 while lanes read A
        ext_addr = 32'h3000;
        set_idx(32'd6, 32'd1);
        do_run();
        send_beats(2, 300, 1'b0);
        check("pp_read_A_mid", 64'(out_o[0 +: DW]), 64'd206);
        send_beats(2, 304, 1'b1);
        check("pp_read_A_lane1", 64'(out_o[DW +: DW]), 64'd201);
        // Disabled run only swaps banks
        disabled = 1'b1;
        do_run();
        disabled = 1'b0;
        check("dis_valid", 64'(databus_valid_0), 64'd0);
        check("dis_done", 64'(done), 64'd1);
        tick();
        tick();
        check("pp_read_B", 64'(out_o[0 +: DW]), 64'd306);
        check("pp_read_B_lane1", 64'(out_o[DW +: DW]), 64'd301);

        // Restart mid-load
        pingPong = 1'b0;
        ext_addr = 32'h4000;
        set_idx(32'd1, 32'd0);
        do_run();
        send_beats(2, 400, 1'b0);
        ext_addr = 32'h5000;
        do_run();
        check("restart_addr", 64'(databus_addr_0), 64'h5000);
        check("restart_done", 64'(done), 64'd0);
        send_beats(4, 50, 1'b1);
        check("restart_done_rose", 64'(done), 64'd1);
        tick();
        check("restart_word0", 64'(out_o[0 +: DW]), 64'd51);
        check("restart_word0_l1", 64'(out_o[DW +: DW]), 64'd50);

        // Reset in the middle of a load
        ext_addr = 32'h6000;
        do_run();
        send_beats(2, 600, 1'b0);
        databus_ready_0 = 1'b1;
        databus_rdata_0 = beat(9, 600);
        rst = 1'b1;
        tick();
        check("rstmid_done", 64'(done), 64'd1);
        check("rstmid_valid", 64'(databus_valid_0), 64'd0);
        check("rstmid_wr_en", 64'(ext_wr_en_o), 64'd0);
        rst = 1'b0;
        repeat (4) tick();
        databus_ready_0 = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
